// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared state type and width helper for the priority grant arbiter.
package prio_arb_pkg;

    typedef enum logic {IDLE, OFFER} arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_onehot_encoder.sv
// prio_onehot_encoder: lowest-index-wins one-hot picker with binary index.
module prio_onehot_encoder #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] vec_i,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        // Scan downward so the lowest set index is the last to overwrite.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_grant_arbiter.sv
// priority_grant_arbiter: latches request pulses and offers one fixed-priority,
// age-promoted grant at a time over a valid/ready handshake.
module priority_grant_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int AGE_LIMIT = 4,
    parameter int ID_W      = clog2_min1(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             gnt_ready_i,
    output logic             gnt_valid_o,
    output logic [N_REQ-1:0] gnt_onehot_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic [N_REQ-1:0] pending_o,
    output logic             busy_o
);

    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    arb_state_t                  state_q, state_d;
    logic [N_REQ-1:0]            pending_q, pending_d;
    logic [N_REQ-1:0][AGE_W-1:0] age_q, age_d;
    logic                        valid_q, valid_d;
    logic [N_REQ-1:0]            onehot_q, onehot_d;
    logic [ID_W-1:0]             id_q, id_d;

    logic [N_REQ-1:0] accept, aged, aged_oh, pend_oh, sel_oh;
    logic [ID_W-1:0]  aged_id, pend_id, sel_id;
    logic             take, done;

    prio_onehot_encoder #(.N(N_REQ), .W(ID_W)) u_aged_enc (
        .vec_i    (aged),
        .onehot_o (aged_oh),
        .idx_o    (aged_id)
    );

    prio_onehot_encoder #(.N(N_REQ), .W(ID_W)) u_pend_enc (
        .vec_i    (pending_q),
        .onehot_o (pend_oh),
        .idx_o    (pend_id)
    );

    always_comb begin
        accept    = (valid_q && gnt_ready_i) ? onehot_q : '0;
        pending_d = req_i | (pending_q & ~accept);
        aged      = '0;
        age_d     = age_q;
        for (int i = 0; i < N_REQ; i++) begin
            aged[i]  = pending_q[i] && (age_q[i] >= AGE_MAX);
            age_d[i] = !pending_q[i] ? '0 :
                       !(|accept)    ? age_q[i] :
                       accept[i]     ? '0 :
                       (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + 1'b1;
        end
        sel_oh   = (|aged) ? aged_oh : pend_oh;
        sel_id   = (|aged) ? aged_id : pend_id;
        take     = (state_q == IDLE) && (|pending_q);
        done     = (state_q == OFFER) && gnt_ready_i;
        state_d  = take ? OFFER  : done ? IDLE : state_q;
        valid_d  = take ? 1'b1   : done ? 1'b0 : valid_q;
        onehot_d = take ? sel_oh : done ? '0   : onehot_q;
        id_d     = take ? sel_id : done ? '0   : id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            age_q     <= '0;
            valid_q   <= 1'b0;
            onehot_q  <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            age_q     <= age_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            id_q      <= id_d;
        end
    end

    assign gnt_valid_o  = valid_q;
    assign gnt_onehot_o = onehot_q;
    assign gnt_id_o     = id_q;
    assign pending_o    = pending_q;
    assign busy_o       = (state_q == OFFER);

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// tb_priority_grant_arbiter: directed vectors with hand-computed expectations.
module tb_priority_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_i;
    logic       gnt_ready_i;
    logic       gnt_valid_o;
    logic [2:0] gnt_onehot_o;
    logic [1:0] gnt_id_o;
    logic [2:0] pending_o;
    logic       busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    priority_grant_arbiter #(.N_REQ(3), .AGE_LIMIT(4), .ID_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .gnt_ready_i  (gnt_ready_i),
        .gnt_valid_o  (gnt_valid_o),
        .gnt_onehot_o (gnt_onehot_o),
        .gnt_id_o     (gnt_id_o),
        .pending_o    (pending_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [1:0] id);
        logic [2:0] oh;
        oh = 3'b001 << id;
        check({tag, ".valid"}, gnt_valid_o, 1);
        check({tag, ".id"}, gnt_id_o, id);
        check({tag, ".onehot"}, gnt_onehot_o, oh);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".valid"}, gnt_valid_o, 0);
        check({tag, ".onehot"}, gnt_onehot_o, 0);
        check({tag, ".id"}, gnt_id_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] starve_ids [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        rst_n       = 1'b0;
        req_i       = 3'b111;
        gnt_ready_i = 1'b0;
        tick();
        tick();
        check_quiet("rst_hold");
        check("rst_hold.pending", pending_o, 0);
        check("rst_hold.busy", busy_o, 0);
        rst_n = 1'b1;
        tick();
        check("rst_rel.pending", pending_o, 3'b111);
        check("rst_rel.valid", gnt_valid_o, 0);
        req_i = 3'b000;
        tick();
        check_grant("rst_first", 2'd0);
        tick();
        check("rst_offer.busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_async");
        check("rst_async.pending", pending_o, 0);
        check("rst_async.busy", busy_o, 0);
        req_i = 3'b111;
        rst_n = 1'b1;
        tick();
        req_i = 3'b000;
        tick();
        check_grant("rst_again", 2'd0);
        gnt_ready_i = 1'b1;
        repeat (5) tick();
        check("rst_drain.pending", pending_o, 0);
        check("rst_drain.valid", gnt_valid_o, 0);

        req_i = 3'b110;
        tick();
        check("prio.pending", pending_o, 3'b110);
        check("prio.valid0", gnt_valid_o, 0);
        req_i = 3'b000;
        tick();
        check_grant("prio.g1", 2'd1);
        tick();
        check("prio.bubble", gnt_valid_o, 0);
        check("prio.pend_mid", pending_o, 3'b100);
        tick();
        check_grant("prio.g2", 2'd2);
        tick();
        check("prio.end_valid", gnt_valid_o, 0);
        check("prio.end_pending", pending_o, 0);

        gnt_ready_i = 1'b0;
        req_i = 3'b001;
        tick();
        req_i = 3'b010;
        tick();
        req_i = 3'b000;
        for (int k = 0; k < 5; k++) begin
            check_grant("bp.hold", 2'd0);
            check("bp.busy", busy_o, 1);
            if (k < 4) tick();
        end
        check("bp.pending", pending_o, 3'b011);
        gnt_ready_i = 1'b1;
        tick();
        check("bp.bubble", gnt_valid_o, 0);
        check("bp.pend_mid", pending_o, 3'b010);
        tick();
        check_grant("bp.next", 2'd1);
        tick();
        check("bp.end_pending", pending_o, 0);

        req_i = 3'b111;
        tick();
        req_i = 3'b011;
        tick();
        for (int k = 0; k < 7; k++) begin
            check_grant($sformatf("starve.g%0d", k), starve_ids[k]);
            tick();
            check("starve.bubble", gnt_valid_o, 0);
            tick();
        end
        req_i = 3'b000;
        repeat (6) tick();
        check("starve.end_pending", pending_o, 0);
        check("starve.end_valid", gnt_valid_o, 0);

        req_i = 3'b001;
        tick();
        req_i = 3'b000;
        tick();
        check_grant("sc.first", 2'd0);
        req_i = 3'b001;
        tick();
        req_i = 3'b000;
        check("sc.pending", pending_o, 3'b001);
        check("sc.bubble", gnt_valid_o, 0);
        tick();
        check_grant("sc.again", 2'd0);
        tick();
        check("sc.end_pending", pending_o, 0);

        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle.valid", gnt_valid_o, 0);
            check("idle.busy", busy_o, 0);
            check("idle.pending", pending_o, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
